mem_cache: RTL and testbench

//  Direct-mapped, write-through, write-allocate cache between the LC-3b core's word memory port
//  and the 128-bit line-based physical memory.
//  - CPU-side port matches the core's mem_* signals exactly; the core stalls until mem_resp.
//  - Services read hits in the same cycle; fetches lines on misses; forwards every store to memory.

---
 rtl/mem_cache_if.sv | 31 +++
 rtl/mem_cache.sv | 112 +++++++++++
 tb/tb_mem_cache.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_cache_if.sv
// CPU word port and 128-bit physical-memory line port of the LC-3b cache.
// The slave view belongs to the cache. The master view belongs to the core plus memory side.
interface mem_cache_if;
  logic         mem_read;
  logic         mem_write;
  logic [1:0]   mem_byte_enable;
  logic [15:0]  mem_address;
  logic [15:0]  mem_wdata;
  logic         mem_resp;
  logic [15:0]  mem_rdata;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  modport slave (
    input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    output mem_resp, mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
    input  mem_resp, mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/mem_cache.sv
// Direct-mapped, write-through, write-allocate cache between the LC-3b word port and
// 128-bit line memory.
//   state      | meaning
//   IDLE       | serve read hits combinationally, decode new requests
//   MISS_FETCH | line fetch outstanding; fill the set on pmem_resp
//   WRITE_THRU | merged line being written to memory; acknowledge CPU on pmem_resp
module mem_cache #(
  parameter int SET_BITS = 3
) (
  input  logic       clk,
  input  logic       rst,
  mem_cache_if.slave bus
);
  localparam int NSETS = 1 << SET_BITS;
  localparam int TAG_W = 12 - SET_BITS;

  typedef enum logic [1:0] {IDLE, MISS_FETCH, WRITE_THRU} state_t;

  state_t             state, state_nxt;
  logic [NSETS-1:0]   valid;
  logic [TAG_W-1:0]   tag_arr  [NSETS];
  logic [127:0]       data_arr [NSETS];
  logic [127:0]       wdata_q;

  logic [TAG_W-1:0]    tag;
  logic [SET_BITS-1:0] idx;
  logic [2:0]          off;
  logic [127:0]        line, merged;
  logic                hit, fill_en, wr_hit_en;
  logic                unused_addr0;

  assign tag          = bus.mem_address[15:4+SET_BITS];
  assign idx          = bus.mem_address[3+SET_BITS:4];
  assign off          = bus.mem_address[3:1];
  assign unused_addr0 = bus.mem_address[0];
  assign line         = data_arr[idx];
  assign hit          = valid[idx] && (tag_arr[idx] == tag);

  always_comb begin
    merged = line;
    if (bus.mem_byte_enable[0]) merged[{off, 4'b0000} +: 8] = bus.mem_wdata[7:0];
    if (bus.mem_byte_enable[1]) merged[{off, 4'b1000} +: 8] = bus.mem_wdata[15:8];
  end

  assign bus.mem_rdata    = line[{off, 4'b0000} +: 16];
  assign bus.pmem_address = {tag, idx, 4'b0000};
  assign bus.pmem_wdata   = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
    end else begin
      state <= state_nxt;
      if (fill_en) valid[idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; validity alone decides whether a set is usable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (fill_en) begin
        data_arr[idx] <= bus.pmem_rdata;
        tag_arr[idx]  <= tag;
      end
      if (wr_hit_en) begin
        data_arr[idx] <= merged;
        wdata_q       <= merged;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    bus.mem_resp   = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    fill_en        = 1'b0;
    wr_hit_en      = 1'b0;
    case (state)
      IDLE: begin
        // A write takes priority if both request lines are ever high together.
        if (bus.mem_write) begin
          if (hit) begin
            wr_hit_en = 1'b1;
            state_nxt = WRITE_THRU;
          end else begin
            state_nxt = MISS_FETCH;
          end
        end else if (bus.mem_read) begin
          if (hit) bus.mem_resp = 1'b1;
          else     state_nxt    = MISS_FETCH;
        end
      end
      MISS_FETCH: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          fill_en   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE_THRU: begin
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) begin
          bus.mem_resp = 1'b1;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_cache.sv
// Scoreboard bench for mem_cache: CPU stimulus pushes expected responses and a monitor checks them.
// A memory responder checks each line request against the queue of expected pmem transactions.
module tb_mem_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_cache_if bus();
  mem_cache #(.SET_BITS(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {bit chk; logic [15:0] data;} resp_t;
  typedef struct {bit wr; logic [15:0] addr; logic [127:0] wdata;} pmem_t;

  resp_t resp_q[$];
  pmem_t pmem_q[$];
  logic [127:0] mem_model [logic [15:0]];

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] L10   = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [127:0] L10_W = 128'h7777_6666_5555_4444_3333_22CD_1111_0000;
  localparam logic [127:0] L90   = 128'h9007_9006_9005_9004_9003_9002_9001_9000;
  localparam logic [127:0] L90_W = 128'h9007_9006_9005_BE04_9003_9002_9001_9000;
  localparam logic [127:0] L20   = 128'hA007_A006_A005_A004_A003_A002_A001_A000;
  localparam logic [127:0] L20_W = 128'hA007_A006_A005_A004_A003_A002_1234_A000;

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_pmem(input bit wr, input logic [15:0] addr, input logic [127:0] wd);
    pmem_t e;
    e.wr = wr; e.addr = addr; e.wdata = wd;
    pmem_q.push_back(e);
  endtask

  task automatic cpu_op(input bit wr, input logic [15:0] addr, input logic [1:0] be,
                        input logic [15:0] wd, input logic [15:0] exp_d, input int exp_lat);
    resp_t r;
    int lat;
    r.chk = !wr; r.data = exp_d;
    resp_q.push_back(r);
    @(posedge clk); #1;
    bus.mem_read        = !wr;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wd;
    lat = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        lat = n;
        break;
      end
    end
    check(lat == exp_lat, "mem_resp_latency", lat, exp_lat);
    @(posedge clk); #1;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  // CPU-side monitor
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (bus.mem_resp) begin
        if (resp_q.size() == 0) begin
          check(1'b0, "mem_resp_unexpected", bus.mem_rdata, 0);
        end else begin
          r = resp_q.pop_front();
          if (r.chk) check(bus.mem_rdata === r.data, "mem_rdata", bus.mem_rdata, r.data);
        end
      end
    end
  end

  // Physical memory responder: fixed three-cycle latency, abandons the request on reset.
  initial begin
    pmem_t e;
    bit aborted;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.pmem_read || bus.pmem_write) begin
        check(!(bus.pmem_read && bus.pmem_write), "pmem_exclusive",
              {bus.pmem_read, bus.pmem_write}, 2'b10);
        if (pmem_q.size() == 0) begin
          check(1'b0, "pmem_unexpected", bus.pmem_address, 0);
          e.wr = bus.pmem_write; e.addr = 16'h0000; e.wdata = '0;
        end else begin
          e = pmem_q.pop_front();
          check(bus.pmem_write == e.wr, "pmem_kind", bus.pmem_write, e.wr);
          check(bus.pmem_address === e.addr, "pmem_address", bus.pmem_address, e.addr);
          if (e.wr) check(bus.pmem_wdata === e.wdata, "pmem_wdata", bus.pmem_wdata, e.wdata);
        end
        aborted = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          #1;
          if (e.wr) mem_model[e.addr] = e.wdata;
          bus.pmem_rdata = (!e.wr && mem_model.exists(e.addr)) ? mem_model[e.addr] : '0;
          bus.pmem_resp  = 1'b1;
          @(posedge clk); #1;
          bus.pmem_resp  = 1'b0;
        end
      end
    end
  end

  initial begin
    bit seen;
    mem_model[16'h0010] = L10;
    mem_model[16'h0090] = L90;
    mem_model[16'h0020] = L20;
    rst = 1'b1;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_byte_enable = 2'b00;
    bus.mem_address = 16'h0000; bus.mem_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(bus.mem_resp == 1'b0, "reset_mem_resp", bus.mem_resp, 0);
    check(bus.pmem_read == 1'b0, "reset_pmem_read", bus.pmem_read, 0);
    check(bus.pmem_write == 1'b0, "reset_pmem_write", bus.pmem_write, 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1-2: cold miss then same-line hit
    exp_pmem(0, 16'h0010, '0);
    cpu_op(0, 16'h0010, 2'b00, 16'h0, 16'h0000, 5);
    cpu_op(0, 16'h0012, 2'b00, 16'h0, 16'h1111, 0);
    // 3: low-byte write hit, written through
    exp_pmem(1, 16'h0010, L10_W);
    cpu_op(1, 16'h0014, 2'b01, 16'hABCD, 16'h0, 4);
    cpu_op(0, 16'h0014, 2'b00, 16'h0, 16'h22CD, 0);
    // 4: conflict miss replaces set 1 without a writeback; old line refetched from memory
    exp_pmem(0, 16'h0090, '0);
    cpu_op(0, 16'h0090, 2'b00, 16'h0, 16'h9000, 5);
    exp_pmem(0, 16'h0010, '0);
    cpu_op(0, 16'h0010, 2'b00, 16'h0, 16'h0000, 5);
    cpu_op(0, 16'h0014, 2'b00, 16'h0, 16'h22CD, 0);

    // 5: reset while a fetch is outstanding
    exp_pmem(0, 16'h0090, '0);
    @(posedge clk); #1;
    bus.mem_read = 1'b1; bus.mem_address = 16'h0090;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.pmem_read) begin
        seen = 1'b1;
        break;
      end
    end
    check(seen, "miss_fetch_started", seen, 1);
    @(posedge clk); #1 rst = 1'b1; bus.mem_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check(bus.pmem_read == 1'b0, "pmem_read_after_rst", bus.pmem_read, 0);
    check(bus.mem_resp == 1'b0, "mem_resp_after_rst", bus.mem_resp, 0);
    exp_pmem(0, 16'h0010, '0);
    cpu_op(0, 16'h0010, 2'b00, 16'h0, 16'h0000, 5);

    // 6: empty byte enable still writes through unchanged line
    exp_pmem(1, 16'h0010, L10_W);
    cpu_op(1, 16'h0016, 2'b00, 16'hFFFF, 16'h0, 4);
    cpu_op(0, 16'h0016, 2'b00, 16'h0, 16'h3333, 0);

    // write miss: allocate, then write through high byte
    exp_pmem(0, 16'h0090, '0);
    exp_pmem(1, 16'h0090, L90_W);
    cpu_op(1, 16'h0098, 2'b10, 16'hBEEF, 16'h0, 9);
    cpu_op(0, 16'h0098, 2'b00, 16'h0, 16'hBE04, 0);
    // another set, top word, full-word write
    exp_pmem(0, 16'h0020, '0);
    cpu_op(0, 16'h002E, 2'b00, 16'h0, 16'hA007, 5);
    exp_pmem(1, 16'h0020, L20_W);
    cpu_op(1, 16'h0022, 2'b11, 16'h1234, 16'h0, 4);
    cpu_op(0, 16'h0022, 2'b00, 16'h0, 16'h1234, 0);
    cpu_op(0, 16'h0098, 2'b00, 16'h0, 16'hBE04, 0);

    repeat (6) @(posedge clk);
    check(resp_q.size() == 0, "resp_queue_drained", resp_q.size(), 0);
    check(pmem_q.size() == 0, "pmem_queue_drained", pmem_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
